// File: rtl/move_cmd_sched.sv
// move_cmd_sched: command FIFO and issue sequencer between the UART receiver
// and the command processor of the Knight's Tour robot. Commands are issued
// one at a time; each one gets exactly one response byte.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | nothing in flight; pops the FIFO head when available
// ISSUE     | cmd_out/cmd_vld presented, waiting for cmd_acpt
// WAIT_DONE | accepted, waiting for cal_done/move_done or timeout
// RESP      | send_resp pulse with resp valid, then back to IDLE
//
// Response codes: A5 = done, E1 = move rejected (not calibrated),
// E2 = timed out waiting for done.
module move_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 4000000,
  parameter int TMO_W   = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_in,
  input  logic        cmd_rdy_in,
  output logic [15:0] cmd_out,
  output logic        cmd_vld,
  input  logic        cmd_acpt,
  input  logic        move_done,
  input  logic        cal_done,
  output logic        send_resp,
  output logic [7:0]  resp,
  output logic        q_full,
  output logic        q_empty,
  output logic        ovf,
  output logic        cal_ok,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] RESP_OK   = 8'hA5;
  localparam logic [7:0] RESP_REJ  = 8'hE1;
  localparam logic [7:0] RESP_TMO  = 8'hE2;
  localparam logic [3:0] OP_CAL    = 4'h0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TMO_W-1:0] tmo_cnt;

  logic        pop, push;
  logic [15:0] head;
  logic        reject;
  logic        cur_is_cal;
  logic        done_hit;
  logic        tmo_hit;
  logic        accept;

  logic        load_cmd;
  logic        resp_ld;
  logic [7:0]  resp_code;
  logic        set_cal;

  assign q_empty    = (count == '0);
  assign q_full     = (count == CW'(DEPTH));
  assign busy       = (state != IDLE);
  assign head       = mem[rd_ptr];
  assign pop        = (state == IDLE) && !q_empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push       = cmd_rdy_in && (!q_full || pop);
  assign reject     = (head[15:12] != OP_CAL) && !cal_ok;
  assign cur_is_cal = (cmd_out[15:12] == OP_CAL);
  assign done_hit   = cur_is_cal ? cal_done : move_done;
  assign tmo_hit    = (tmo_cnt == TMO_W'(TMO_CYC - 1));
  assign accept     = (state == ISSUE) && cmd_acpt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pop) state_nxt = reject ? RESP : ISSUE;
      end
      ISSUE: begin
        if (cmd_acpt) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_hit || tmo_hit) state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: what the datapath registers load on this edge
  always_comb begin
    load_cmd  = 1'b0;
    resp_ld   = 1'b0;
    resp_code = 8'h00;
    set_cal   = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          if (reject) begin
            resp_ld   = 1'b1;
            resp_code = RESP_REJ;
          end else begin
            load_cmd  = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        // done takes priority over a timeout landing in the same cycle
        if (done_hit) begin
          resp_ld   = 1'b1;
          resp_code = RESP_OK;
          set_cal   = cur_is_cal;
        end else if (tmo_hit) begin
          resp_ld   = 1'b1;
          resp_code = RESP_TMO;
        end
      end
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cmd_rdy_in && !push) ovf <= 1'b1;
    end
  end

  // Issue handshake, response byte and calibration status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_out   <= 16'h0000;
      cmd_vld   <= 1'b0;
      send_resp <= 1'b0;
      resp      <= 8'h00;
      cal_ok    <= 1'b0;
    end else begin
      if (load_cmd) begin
        cmd_out <= head;
        cmd_vld <= 1'b1;
      end else if (accept) begin
        cmd_vld <= 1'b0;
      end
      send_resp <= resp_ld;
      if (resp_ld) resp <= resp_code;
      if (set_cal) cal_ok <= 1'b1;
    end
  end

  // Stall timer: cleared on accept, counts every WAIT_DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tmo_cnt <= '0;
    else if (accept)             tmo_cnt <= '0;
    else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + 1'b1;
  end

endmodule

// File: tb/tb_move_cmd_sched.sv
// Directed bench for move_cmd_sched: a per-cycle vector table for the
// reject/calibrate flow, then hand sequences for queueing, overflow,
// timeout, done-vs-timeout priority and asynchronous reset.
module tb_move_cmd_sched;

  logic        clk;
  logic        rst;
  logic [15:0] cmd_in;
  logic        cmd_rdy_in;
  logic [15:0] cmd_out;
  logic        cmd_vld;
  logic        cmd_acpt;
  logic        move_done;
  logic        cal_done;
  logic        send_resp;
  logic [7:0]  resp;
  logic        q_full;
  logic        q_empty;
  logic        ovf;
  logic        cal_ok;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;

  move_cmd_sched #(.DEPTH(4), .TMO_CYC(1000), .TMO_W(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_in     (cmd_in),
    .cmd_rdy_in (cmd_rdy_in),
    .cmd_out    (cmd_out),
    .cmd_vld    (cmd_vld),
    .cmd_acpt   (cmd_acpt),
    .move_done  (move_done),
    .cal_done   (cal_done),
    .send_resp  (send_resp),
    .resp       (resp),
    .q_full     (q_full),
    .q_empty    (q_empty),
    .ovf        (ovf),
    .cal_ok     (cal_ok),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [15:0] cmd;
    logic        acpt;
    logic        mdone;
    logic        cdone;
    logic        vld;
    logic [15:0] out;
    logic        sr;
    logic [7:0]  rsp;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        calok;
    logic        busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one clock; responses are tallied here so every sequence sees them
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (send_resp) rsp_cnt++;
  endtask

  task automatic push(input logic [15:0] c);
    cmd_in     = c;
    cmd_rdy_in = 1'b1;
    tick();
    cmd_rdy_in = 1'b0;
  endtask

  task automatic wait_vld(input string name);
    int n = 0;
    while (!cmd_vld && n < 20) begin
      tick();
      n++;
    end
    chk(name, cmd_vld, 1);
  endtask

  task automatic accept_cmd();
    cmd_acpt = 1'b1;
    tick();
    cmd_acpt = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".cmd_out"},   cmd_out,   16'h0000);
    chk({tag, ".cmd_vld"},   cmd_vld,   0);
    chk({tag, ".send_resp"}, send_resp, 0);
    chk({tag, ".resp"},      resp,      8'h00);
    chk({tag, ".q_empty"},   q_empty,   1);
    chk({tag, ".q_full"},    q_full,    0);
    chk({tag, ".ovf"},       ovf,       0);
    chk({tag, ".cal_ok"},    cal_ok,    0);
    chk({tag, ".busy"},      busy,      0);
  endtask

  logic [15:0] moves [4];
  int rsp0;

  initial begin
    //            rdy cmd       ac md cd  vld out       sr rsp    em fu ov ca bz
    vecs[0]  = '{1, 16'h2bf1, 0, 0, 0,  0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 16'h0000, 0, 0, 0,  0, 16'h0000, 1, 8'hE1, 1, 0, 0, 0, 1};
    vecs[2]  = '{0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 8'hE1, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 8'hE1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 16'h0000, 0, 0, 0,  1, 16'h0000, 0, 8'hE1, 1, 0, 0, 0, 1};
    vecs[5]  = '{0, 16'h0000, 0, 1, 1,  1, 16'h0000, 0, 8'hE1, 1, 0, 0, 0, 1};
    vecs[6]  = '{0, 16'h0000, 0, 0, 0,  1, 16'h0000, 0, 8'hE1, 1, 0, 0, 0, 1};
    vecs[7]  = '{0, 16'h0000, 1, 0, 0,  0, 16'h0000, 0, 8'hE1, 1, 0, 0, 0, 1};
    vecs[8]  = '{0, 16'h0000, 0, 1, 0,  0, 16'h0000, 0, 8'hE1, 1, 0, 0, 0, 1};
    vecs[9]  = '{0, 16'h0000, 0, 0, 1,  0, 16'h0000, 1, 8'hA5, 1, 0, 0, 1, 1};
    vecs[10] = '{0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 8'hA5, 1, 0, 0, 1, 0};

    moves[0] = 16'h2bf1;
    moves[1] = 16'h2001;
    moves[2] = 16'h23f1;
    moves[3] = 16'h27f1;

    rst        = 1'b1;
    cmd_in     = 16'h0000;
    cmd_rdy_in = 1'b0;
    cmd_acpt   = 1'b0;
    move_done  = 1'b0;
    cal_done   = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // reject before calibration, then a calibrate with ignored done pulses
    for (int i = 0; i < 11; i++) begin
      cmd_rdy_in = vecs[i].rdy;
      cmd_in     = vecs[i].cmd;
      cmd_acpt   = vecs[i].acpt;
      move_done  = vecs[i].mdone;
      cal_done   = vecs[i].cdone;
      tick();
      chk($sformatf("v%0d.cmd_vld", i),   cmd_vld,   vecs[i].vld);
      chk($sformatf("v%0d.cmd_out", i),   cmd_out,   vecs[i].out);
      chk($sformatf("v%0d.send_resp", i), send_resp, vecs[i].sr);
      chk($sformatf("v%0d.resp", i),      resp,      vecs[i].rsp);
      chk($sformatf("v%0d.q_empty", i),   q_empty,   vecs[i].empty);
      chk($sformatf("v%0d.q_full", i),    q_full,    vecs[i].full);
      chk($sformatf("v%0d.ovf", i),       ovf,       vecs[i].ovf);
      chk($sformatf("v%0d.cal_ok", i),    cal_ok,    vecs[i].calok);
      chk($sformatf("v%0d.busy", i),      busy,      vecs[i].busy);
    end
    cmd_rdy_in = 1'b0;
    cmd_acpt   = 1'b0;
    move_done  = 1'b0;
    cal_done   = 1'b0;
    chk("table.rsp_cnt", rsp_cnt, 2);

    // recalibrate; fill the FIFO while it waits, then overflow it
    rsp0 = rsp_cnt;
    push(16'h0000);
    wait_vld("recal.vld");
    chk("recal.cmd_out", cmd_out, 16'h0000);
    accept_cmd();
    for (int i = 0; i < 4; i++) push(moves[i]);
    chk("fill.q_full", q_full, 1);
    chk("fill.q_empty", q_empty, 0);
    chk("fill.ovf_clear", ovf, 0);
    push(16'h2ff1);
    chk("drop.ovf", ovf, 1);
    chk("drop.q_full", q_full, 1);
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    chk("recal.send_resp", send_resp, 1);
    chk("recal.resp", resp, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      wait_vld($sformatf("mv%0d.vld", i));
      chk($sformatf("mv%0d.cmd_out", i), cmd_out, moves[i]);
      chk($sformatf("mv%0d.order", i), rsp_cnt - rsp0, 1 + i);
      accept_cmd();
      repeat (2) tick();
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
      chk($sformatf("mv%0d.send_resp", i), send_resp, 1);
      chk($sformatf("mv%0d.resp", i), resp, 8'hA5);
    end
    repeat (6) tick();
    chk("drain.cmd_vld", cmd_vld, 0);
    chk("drain.q_empty", q_empty, 1);
    chk("drain.rsp_total", rsp_cnt - rsp0, 5);
    chk("drain.ovf_sticky", ovf, 1);

    // timeout exactly TMO_CYC cycles after the accepting edge
    push(16'h2001);
    wait_vld("tmo.vld");
    chk("tmo.cmd_out", cmd_out, 16'h2001);
    push(16'h23f1);
    chk("tmo.still_issue", cmd_vld, 1);
    accept_cmd();
    rsp0 = rsp_cnt;
    for (int n = 1; n < 1000; n++) tick();
    chk("tmo.early", rsp_cnt - rsp0, 0);
    tick();
    chk("tmo.send_resp", send_resp, 1);
    chk("tmo.resp", resp, 8'hE2);
    chk("tmo.cal_ok", cal_ok, 1);
    wait_vld("tmo.next_vld");
    chk("tmo.next_cmd", cmd_out, 16'h23f1);

    // done arriving on the timeout cycle wins
    accept_cmd();
    rsp0 = rsp_cnt;
    for (int n = 1; n < 1000; n++) tick();
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    chk("tie.early", rsp_cnt - rsp0, 1);
    chk("tie.send_resp", send_resp, 1);
    chk("tie.resp", resp, 8'hA5);

    // asynchronous reset in WAIT_DONE with two commands queued
    repeat (2) tick();
    push(16'h2001);
    wait_vld("rst.vld");
    accept_cmd();
    push(16'h23f1);
    push(16'h27f1);
    chk("rst.pre_busy", busy, 1);
    chk("rst.pre_q_empty", q_empty, 0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_async");
    rsp0 = rsp_cnt;
    repeat (2) tick();
    rst = 1'b0;
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    repeat (5) tick();
    chk("rst.no_vld", cmd_vld, 0);
    chk("rst.no_resp", rsp_cnt - rsp0, 0);
    chk("rst.busy", busy, 0);
    chk("rst.q_empty", q_empty, 1);
    chk("rst.cal_ok", cal_ok, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
